// File: rtl/xor_share_arb.sv
// Round-robin arbiter feeding one shared XOR mask unit with a registered result.
// Optional per-requester grant counters under `ARB_STATS_EN.
module xor_share_arb #(
  parameter int             WIDTH      = 2,
  parameter logic [WIDTH-1:0] MASK_RESET = '0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  input  logic             cfg_we,
  input  logic [WIDTH-1:0] cfg_mask,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data,
  output logic             res_id,
`ifdef ARB_STATS_EN
  output logic [7:0]       gnt_cnt0,
  output logic [7:0]       gnt_cnt1,
`endif
  input  logic             res_ready
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t           state;
  logic [WIDTH-1:0] mask;
  logic             prio;
  logic             space;
  logic             gnt0;
  logic             gnt1;
  logic             accept;
  logic [WIDTH-1:0] op;

  assign res_valid = (state == FULL);
  assign space     = !res_valid || res_ready;

  // Contention is settled by prio; a lone requester always wins.
  assign gnt0 = req0_valid && (!req1_valid || !prio);
  assign gnt1 = req1_valid && (!req0_valid || prio);

  assign req0_ready = space && gnt0;
  assign req1_ready = space && gnt1;
  assign accept     = req0_ready || req1_ready;
  assign op         = gnt1 ? req1_data : req0_data;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= EMPTY;
      res_data <= '0;
      res_id   <= 1'b0;
      mask     <= MASK_RESET;
      prio     <= 1'b0;
    end else begin
      if (cfg_we)
        mask <= cfg_mask;
      unique case (1'b1)
        accept: begin
          state    <= FULL;
          res_data <= op ^ mask;
          res_id   <= gnt1;
          prio     <= ~gnt1;
        end
        (!accept && res_valid && res_ready):
          state <= EMPTY;
        default: ;
      endcase
    end
  end

`ifdef ARB_STATS_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      gnt_cnt0 <= '0;
      gnt_cnt1 <= '0;
    end else begin
      if (req0_ready && gnt_cnt0 != 8'hff)
        gnt_cnt0 <= gnt_cnt0 + 8'd1;
      if (req1_ready && gnt_cnt1 != 8'hff)
        gnt_cnt1 <= gnt_cnt1 + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_xor_share_arb.sv
// Directed self-checking bench for xor_share_arb with a result scoreboard.
// Counter checks run only when ARB_STATS_EN is defined.
module tb_xor_share_arb;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       req0_valid = 1'b0;
  logic [1:0] req0_data = '0;
  logic       req0_ready;
  logic       req1_valid = 1'b0;
  logic [1:0] req1_data = '0;
  logic       req1_ready;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_mask = '0;
  logic       res_valid;
  logic [1:0] res_data;
  logic       res_id;
  logic       res_ready = 1'b0;
`ifdef ARB_STATS_EN
  logic [7:0] gnt_cnt0;
  logic [7:0] gnt_cnt1;
`endif

  xor_share_arb #(.WIDTH(2), .MASK_RESET(2'b00)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .req0_valid(req0_valid),
    .req0_data(req0_data),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid),
    .req1_data(req1_data),
    .req1_ready(req1_ready),
    .cfg_we(cfg_we),
    .cfg_mask(cfg_mask),
    .res_valid(res_valid),
    .res_data(res_data),
    .res_id(res_id),
`ifdef ARB_STATS_EN
    .gnt_cnt0(gnt_cnt0),
    .gnt_cnt1(gnt_cnt1),
`endif
    .res_ready(res_ready)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  logic [2:0] sb[$];
  logic       m_valid;
  logic [1:0] m_data;
  logic       m_id;
  logic [1:0] m_mask;
  logic       m_prio;
  int         m_cnt0;
  int         m_cnt1;

  task automatic check(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_data = 0; m_id = 0;
    m_mask = 0; m_prio = 0; m_cnt0 = 0; m_cnt1 = 0;
    sb.delete();
  endtask

  // Called just after a negedge; returns just after the next negedge.
  task automatic step(input logic v0, input logic [1:0] d0,
                      input logic v1, input logic [1:0] d1,
                      input logic rr, input logic we,
                      input logic [1:0] m);
    logic sp, g0, g1, acc;
    logic [2:0] e;
    req0_valid = v0; req0_data = d0;
    req1_valid = v1; req1_data = d1;
    res_ready = rr; cfg_we = we; cfg_mask = m;
    #1;
    sp = !m_valid || rr;
    g0 = v0 && (!v1 || !m_prio);
    g1 = v1 && (!v0 || m_prio);
    check("req0_ready", {7'b0, req0_ready}, {7'b0, sp && g0});
    check("req1_ready", {7'b0, req1_ready}, {7'b0, sp && g1});
    acc = sp && (g0 || g1);
    if (acc) begin
      if (g1) sb.push_back({1'b1, d1 ^ m_mask});
      else    sb.push_back({1'b0, d0 ^ m_mask});
    end
    @(posedge clock);
    #1;
    if (acc) begin
      e = sb.pop_front();
      m_valid = 1; m_id = e[2]; m_data = e[1:0];
      m_prio = ~e[2];
      if (e[2]) m_cnt1 = (m_cnt1 < 255) ? m_cnt1 + 1 : 255;
      else      m_cnt0 = (m_cnt0 < 255) ? m_cnt0 + 1 : 255;
    end else if (rr) begin
      m_valid = 0;
    end
    if (we) m_mask = m;
    check("res_valid", {7'b0, res_valid}, {7'b0, m_valid});
    check("res_data", {6'b0, res_data}, {6'b0, m_data});
    check("res_id", {7'b0, res_id}, {7'b0, m_id});
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    check("rst_valid", {7'b0, res_valid}, 8'd0);
    check("rst_data", {6'b0, res_data}, 8'd0);
    check("rst_id", {7'b0, res_id}, 8'd0);
`ifdef ARB_STATS_EN
    check("rst_cnt0", gnt_cnt0, 8'd0);
    check("rst_cnt1", gnt_cnt1, 8'd0);
`endif
    #2;
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  initial begin
    model_reset();
    #2;
    check("por_valid", {7'b0, res_valid}, 8'd0);
    check("por_data", {6'b0, res_data}, 8'd0);
    check("por_id", {7'b0, res_id}, 8'd0);
    #10;
    reset_n = 1'b1;
    @(negedge clock);

    // single request, mask 00
    step(1, 2'b01, 0, 2'b00, 1, 0, 2'b00);
    // mask write while draining, then req1
    step(0, 2'b00, 0, 2'b00, 1, 1, 2'b11);
    step(0, 2'b00, 1, 2'b01, 1, 0, 2'b00);
    step(0, 2'b00, 0, 2'b00, 1, 0, 2'b00);

    // fresh contention alternates 0,1,0,1
    do_reset();
    step(1, 2'b00, 1, 2'b11, 1, 0, 2'b00);
    step(1, 2'b01, 1, 2'b10, 1, 0, 2'b00);
    step(1, 2'b10, 1, 2'b01, 1, 0, 2'b00);
    step(1, 2'b11, 1, 2'b00, 1, 0, 2'b00);

    // backpressure holds result and blocks both
    for (int i = 0; i < 3; i++)
      step(1, 2'b10, 1, 2'b01, 0, 0, 2'b00);
    step(1, 2'b10, 1, 2'b01, 1, 0, 2'b00);
    step(1, 2'b11, 1, 2'b10, 1, 0, 2'b00);

    // same-cycle mask write uses old mask
    step(1, 2'b01, 0, 2'b00, 1, 1, 2'b11);
    step(1, 2'b01, 0, 2'b00, 1, 0, 2'b00);
    // drain: data holds
    step(0, 2'b00, 0, 2'b00, 1, 0, 2'b00);
    step(0, 2'b00, 0, 2'b00, 0, 0, 2'b00);

    // lone requester sees prio irrelevant
    step(0, 2'b00, 1, 2'b10, 1, 0, 2'b00);
    step(0, 2'b00, 1, 2'b01, 1, 0, 2'b00);

    // async reset while FULL
    do_reset();

`ifdef ARB_STATS_EN
    for (int i = 0; i < 300; i++)
      step(1, 2'(i), 0, 2'b00, 1, 0, 2'b00);
    check("gnt_cnt0", gnt_cnt0, 8'(m_cnt0));
    check("gnt_cnt1", gnt_cnt1, 8'(m_cnt1));
    check("cnt0_sat", gnt_cnt0, 8'd255);
    check("cnt1_zero", gnt_cnt1, 8'd0);
    do_reset();
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
